toggle_decoder: RTL

Receive-side decoder for toggle-encoded event lines, such as the output of a T flip-flop whose `t` input is pulsed once per event. Every transition of the input line, rising or falling, is one event. Events are converted into a counted, back-pressurable valid/ready event stream, and a wrapping total-edge count is kept. The block sits on the consumer side of any toggle-signalled event path in the sequential-circuits library.

---
 rtl/toggle_dec_pkg.sv | 27 ++
 rtl/toggle_dec_sync.sv | 31 +++
 rtl/toggle_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/toggle_dec_pkg.sv
// toggle_dec_pkg: shared types and constants for the toggle-encoded event
// decoder (toggle_decoder and its optional input synchronizer).
package toggle_dec_pkg;

  // Decoder control state: ARM settles the edge detector, RUN counts edges.
  typedef enum logic [0:0] {
    ARM = 1'b0,
    RUN = 1'b1
  } tdec_state_e;

  // Depth of the optional input synchronizer.
  localparam int SYNC_STAGES = 2;

  // Cycles spent in ARM. With the synchronizer, ARM must outlast the
  // synchronizer pipeline so t_prev captures a flushed, settled level.
  localparam int ARM_CYCLES_NOSYNC = 1;
  localparam int ARM_CYCLES_SYNC   = SYNC_STAGES + 1;

  // Width of the ARM cycle counter; large enough for either ARM length.
  localparam int ARM_CNT_W = 2;

  // Last ARM counter value before moving to RUN, for a given ARM length.
  function automatic logic [ARM_CNT_W-1:0] arm_last(input int arm_len);
    arm_last = ARM_CNT_W'(arm_len - 1);
  endfunction

endpackage

// File: rtl/toggle_dec_sync.sv
// toggle_dec_sync: multi-flop synchronizer for the asynchronous toggle line.
// Every stage resets to 0 so the decoder re-arms from a known level.
module toggle_dec_sync
  import toggle_dec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw line into the bottom of the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchronizer flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// toggle_decoder: turns every transition of a toggle-encoded line into one
// event on a valid/ready stream, with a saturating pending count, a sticky
// overflow flag and a wrapping total-edge count.
//
// Build option: define TOGGLE_DEC_SYNC_EN to pass t_in through a two-flop
// synchronizer (t_in may then be asynchronous; latency 4 cycles, ARM 3
// cycles). Without it t_in must be synchronous (latency 2, ARM 1 cycle).
//
// Handshake: an event is offered while ev_valid (pend != 0); it is consumed
// at the posedge where ev_valid && ev_ready. ev_ready with ev_valid low is
// ignored. ev_valid may stay high across back-to-back accepts.
module toggle_decoder
  import toggle_dec_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int TOT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pend,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  output logic             level
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  // Line as seen by the edge detector (optionally synchronized).
  logic line_s;

`ifdef TOGGLE_DEC_SYNC_EN
  localparam int ARM_LEN = ARM_CYCLES_SYNC;

  toggle_dec_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (t_in),
    .q   (line_s)
  );
`else
  localparam int ARM_LEN = ARM_CYCLES_NOSYNC;

  assign line_s = t_in;
`endif

  localparam logic [ARM_CNT_W-1:0] ARM_LAST = arm_last(ARM_LEN);

  // State and datapath registers.
  tdec_state_e            state_q,    state_d;
  logic [ARM_CNT_W-1:0]   arm_cnt_q,  arm_cnt_d;
  logic                   t_q,        t_d;
  logic                   t_prev_q,   t_prev_d;
  logic [CNT_W-1:0]       pend_q,     pend_d;
  logic [TOT_W-1:0]       total_q,    total_d;
  logic                   overflow_q, overflow_d;

  logic edge_det;
  logic acc;

  // ARM/RUN sequencing: ARM counts out its settling cycles, then RUN forever.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = RUN;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d   = ARM;
        arm_cnt_d = '0;
      end
    endcase
  end

  // Edge detect. In ARM, t_prev takes the same value t_q is loading, so the
  // pair agrees on entry to RUN and the level at reset release is not an edge.
  always_comb begin
    t_d      = line_s;
    t_prev_d = (state_q == ARM) ? t_d : t_q;
    edge_det = (state_q == RUN) && (t_q ^ t_prev_q);
  end

  // Pending, total and overflow updates. An edge against a saturated pending
  // count with no accept is lost and flagged; total counts it regardless.
  always_comb begin
    acc        = ev_valid && ev_ready;
    pend_d     = pend_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    if (edge_det) begin
      total_d = total_q + 1'b1;
    end
    case ({edge_det, acc})
      2'b10: begin
        if (pend_q == PEND_MAX) begin
          overflow_d = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end
      2'b01: begin
        pend_d = pend_q - 1'b1;
      end
      default: begin
        pend_d = pend_q;
      end
    endcase
  end

  // All registers, synchronous active-high reset; reset re-enters ARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARM;
      arm_cnt_q  <= '0;
      t_q        <= 1'b0;
      t_prev_q   <= 1'b0;
      pend_q     <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      t_q        <= t_d;
      t_prev_q   <= t_prev_d;
      pend_q     <= pend_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid = (pend_q != '0);
  assign pend     = pend_q;
  assign total    = total_q;
  assign overflow = overflow_q;
  assign level    = t_q;

endmodule
